// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared types and helpers for the seq_gen_tx serial transmitter.
//   seq_gen_state_t : transmitter FSM states (IDLE, SHIFT, DONE)
//   seq_gen_nbits() : number of serial bits per word for a given data width
// Build option: SEQ_GEN_TX_PARITY_EN appends an even-parity bit to every word.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seq_gen_state_t;

  // Bits on the wire per word: the data bits, plus one parity bit when enabled.
  function automatic int seq_gen_nbits(input int width);
`ifdef SEQ_GEN_TX_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/seq_gen_tx_bit_timer.sv
// bit_timer: bit-period counter for seq_gen_tx.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   run   : count while high; counter held at 0 while low
//   tick  : high on the last cycle of each BIT_CYCLES-long bit period
// With BIT_CYCLES=1 the counter never leaves 0 and tick simply follows run.
module bit_timer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seq_gen_tx.sv
// seq_gen_tx: serial bit-stream transmitter (MSB first on d/en).
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   start : load request, accepted on a rising edge while ready=1
//   data  : WIDTH-bit word captured when start is accepted
//   ready : idle / able to accept start (also high in the DONE cycle)
//   d     : serial data bit
//   en    : high while d carries a valid bit
//   done  : one-cycle pulse after the last bit period
// Parameters: WIDTH (>=2) data bits, BIT_CYCLES (>=1) clocks per bit.
// Build option: SEQ_GEN_TX_PARITY_EN appends an even-parity bit after the LSB.
module seq_gen_tx
  import seq_gen_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             d,
  output logic             en,
  output logic             done
);

  localparam int NBITS = seq_gen_nbits(WIDTH);
  localparam int BW    = $clog2(NBITS);

  seq_gen_state_t   state, state_n;
  logic [NBITS-1:0] sreg, sreg_n, load_word;
  logic [BW-1:0]    bitcnt, bitcnt_n;
  logic             run, tick;
  logic             d_n, en_n, done_n, ready_n;

`ifdef SEQ_GEN_TX_PARITY_EN
  assign load_word = {data, ^data};
`else
  assign load_word = data;
`endif

  assign run = (state == SHIFT);

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tick  (tick)
  );

  always_comb begin
    state_n  = state;
    sreg_n   = sreg;
    bitcnt_n = bitcnt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n  = SHIFT;
          sreg_n   = load_word;
          bitcnt_n = BW'(NBITS - 1);
        end else begin
          state_n  = IDLE;
        end
      end
      SHIFT: begin
        if (tick) begin
          sreg_n = {sreg[NBITS-2:0], 1'b0};
          if (bitcnt == '0) begin
            state_n = DONE;
          end else begin
            bitcnt_n = bitcnt - BW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are decoded from the next-state values and then registered,
    // so they change on the same edge as the state with no path from start/data.
    en_n    = (state_n == SHIFT);
    d_n     = en_n & sreg_n[NBITS-1];
    done_n  = (state_n == DONE);
    ready_n = (state_n != SHIFT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sreg   <= '0;
      bitcnt <= '0;
      d      <= 1'b0;
      en     <= 1'b0;
      done   <= 1'b0;
      ready  <= 1'b1;
    end else begin
      state  <= state_n;
      sreg   <= sreg_n;
      bitcnt <= bitcnt_n;
      d      <= d_n;
      en     <= en_n;
      done   <= done_n;
      ready  <= ready_n;
    end
  end

endmodule

// File: tb/tb_seq_gen_tx.sv
// tb_seq_gen_tx: directed, self-checking bench for seq_gen_tx.
// Two instances: u_dut1 (WIDTH=8, BIT_CYCLES=1) and u_dut3 (WIDTH=8, BIT_CYCLES=3).
// Outputs are compared as the 4-bit group {ready, d, en, done}.
// Build option: SEQ_GEN_TX_PARITY_EN (bench expects the appended parity bit).
module tb_seq_gen_tx;

`ifdef SEQ_GEN_TX_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start1, start3;
  logic [7:0] data1, data3;
  logic       ready1, d1, en1, done1;
  logic       ready3, d3, en3, done3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_gen_tx #(.WIDTH(8), .BIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .data(data1),
    .ready(ready1), .d(d1), .en(en1), .done(done1)
  );

  seq_gen_tx #(.WIDTH(8), .BIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .data(data3),
    .ready(ready3), .d(d3), .en(en3), .done(done3)
  );

  typedef struct {
    logic       start;
    logic [7:0] data;
    logic [3:0] exp;   // {ready, d, en, done}
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: {ready,d,en,done} got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Send one word on u_dut1; word holds the expected wire bits MSB-aligned
  // ({data, parity}); only the first NB bits are expected on d.
  task automatic send1(input logic [7:0] dat, input logic [8:0] word, input string tag);
    start1 = 1'b1;
    data1  = dat;
    step;
    start1 = 1'b0;
    for (int k = 0; k < NB; k++) begin
      chk($sformatf("%s_bit%0d", tag, k), {ready1, d1, en1, done1}, {1'b0, word[8-k], 1'b1, 1'b0});
      step;
    end
    chk($sformatf("%s_done", tag), {ready1, d1, en1, done1}, 4'b1001);
    step;
    chk($sformatf("%s_idle", tag), {ready1, d1, en1, done1}, 4'b1000);
  endtask

  initial begin
    logic [8:0] w1, w2;

    // Reset, with start pulsed while reset is held.
    reset  = 1'b0;
    start1 = 1'b1; data1 = 8'hFF;
    start3 = 1'b1; data3 = 8'hFF;
    step;
    step;
    chk("rst1", {ready1, d1, en1, done1}, 4'b1000);
    chk("rst3", {ready3, d3, en3, done3}, 4'b1000);
    start1 = 1'b0;
    start3 = 1'b0;
    reset  = 1'b1;
    step;
    chk("post_rst1", {ready1, d1, en1, done1}, 4'b1000);
    chk("post_rst3", {ready3, d3, en3, done3}, 4'b1000);

    // Basic send of 8'hA5 = 1010_0101, parity 0.
    vecs.push_back('{1'b1, 8'hA5, 4'b0110});
    vecs.push_back('{1'b0, 8'h00, 4'b0010});
    vecs.push_back('{1'b0, 8'h00, 4'b0110});
    vecs.push_back('{1'b0, 8'h00, 4'b0010});
    vecs.push_back('{1'b0, 8'h00, 4'b0010});
    vecs.push_back('{1'b0, 8'h00, 4'b0110});
    vecs.push_back('{1'b0, 8'h00, 4'b0010});
    vecs.push_back('{1'b0, 8'h00, 4'b0110});
`ifdef SEQ_GEN_TX_PARITY_EN
    vecs.push_back('{1'b0, 8'h00, 4'b0010});
`endif
    vecs.push_back('{1'b0, 8'h00, 4'b1001});
    vecs.push_back('{1'b0, 8'h00, 4'b1000});
    foreach (vecs[i]) begin
      start1 = vecs[i].start;
      data1  = vecs[i].data;
      step;
      chk($sformatf("a5_vec%0d", i), {ready1, d1, en1, done1}, vecs[i].exp);
    end

    // Stretched bits: 8'h81 at 3 cycles/bit (parity 0).
    start3 = 1'b1;
    data3  = 8'h81;
    step;
    start3 = 1'b0;
    for (int c = 0; c < NB * 3; c++) begin
      logic expd;
      expd = (c < 3) || (c >= 21 && c < 24);
      chk($sformatf("str_c%0d", c), {ready3, d3, en3, done3}, {1'b0, expd, 1'b1, 1'b0});
      step;
    end
    chk("str_done", {ready3, d3, en3, done3}, 4'b1001);
    step;
    chk("str_idle", {ready3, d3, en3, done3}, 4'b1000);

    // Back-to-back with start held high and data changed mid-word.
    w1 = {8'hC3, 1'b0};
    w2 = {8'h5A, 1'b0};
    start1 = 1'b1;
    data1  = 8'hC3;
    step;
    for (int k = 0; k < NB; k++) begin
      chk($sformatf("b2b_w1_bit%0d", k), {ready1, d1, en1, done1}, {1'b0, w1[8-k], 1'b1, 1'b0});
      if (k == 2) data1 = 8'h5A;
      step;
    end
    chk("b2b_gap", {ready1, d1, en1, done1}, 4'b1001);
    step;
    for (int k = 0; k < NB; k++) begin
      chk($sformatf("b2b_w2_bit%0d", k), {ready1, d1, en1, done1}, {1'b0, w2[8-k], 1'b1, 1'b0});
      if (k == 0) start1 = 1'b0;
      step;
    end
    chk("b2b_done2", {ready1, d1, en1, done1}, 4'b1001);
    step;
    chk("b2b_idle", {ready1, d1, en1, done1}, 4'b1000);

    // Abort during bit 4 of 8'hFF.
    start1 = 1'b1;
    data1  = 8'hFF;
    step;
    start1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("abort_bit%0d", k), {ready1, d1, en1, done1}, 4'b0110);
      step;
    end
    chk("abort_bit4", {ready1, d1, en1, done1}, 4'b0110);
    #2 reset = 1'b0;
    #1 chk("abort_now", {ready1, d1, en1, done1}, 4'b1000);
    step;
    chk("abort_hold", {ready1, d1, en1, done1}, 4'b1000);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step;
      chk($sformatf("abort_after%0d", k), {ready1, d1, en1, done1}, 4'b1000);
    end
    send1(8'h3C, {8'h3C, 1'b0}, "recover");

    // Parity cases (8'h07 -> parity 1, 8'h03 -> parity 0); without parity
    // the trailing bit is simply not sent.
    send1(8'h07, {8'h07, 1'b1}, "p07");
    send1(8'h03, {8'h03, 1'b0}, "p03");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
